fifo_write_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of `asynchronous_fifo` among `NUM_REQ` producers in the write clock domain. It grants one requester per cycle, limits how many consecutive words one owner may write, and stalls all grants while the FIFO reports `full`. It drives `w_en` and `data_in` of the FIFO directly and sits between the producer blocks and the FIFO write side.

---
 rtl/fifo_write_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Purpose : round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with a burst cap per grant.
// Latency : zero; gnt/w_en/data_in are combinational and the word is written at the same w_clk edge.
// Backpr. : full=1 withholds every grant and freezes owner/burst_cnt, so w_en is never raised into a full FIFO.
//
// Ports:
//   w_clk, wrst         write-domain clock, synchronous active-high reset
//   req, req_data       per-requester request and word (slice i*DATA_SIZE +: DATA_SIZE)
//   full                FIFO full flag
//   gnt, w_en, data_in  one-hot grant, FIFO write enable, granted word (0 when idle)
//   owner, burst_cnt    last granted requester and words written in its current burst
//   busy, word_count    burst in progress; saturating total of words written
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4,
  localparam int OW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                           w_clk,
  input  logic                           wrst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  input  logic                           full,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           w_en,
  output logic [DATA_SIZE-1:0]           data_in,
  output logic [OW-1:0]                  owner,
  output logic [BW-1:0]                  burst_cnt,
  output logic                           busy,
  output logic [15:0]                    word_count
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [15:0]   word_count_q, word_count_d;

  logic          cont;
  logic          found;
  logic [OW-1:0] winner;
  logic [OW-1:0] idx;
  logic [OW-1:0] gnt_idx;
  logic          grant_vld;

  // Grant selection. The search starts one past the current owner and wraps,
  // so the owner itself is the last candidate considered.
  always_comb begin
    cont   = (state_q == BURST) && req[owner_q] && (burst_cnt_q < BW'(MAX_BURST));
    found  = 1'b0;
    winner = owner_q;
    idx    = owner_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = OW'((int'(owner_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    gnt_idx   = cont ? owner_q : winner;
    grant_vld = !wrst && !full && (cont || found);
  end

  assign gnt     = grant_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign w_en    = grant_vld;
  assign data_in = grant_vld ? req_data[int'(gnt_idx)*DATA_SIZE +: DATA_SIZE] : '0;

  // Next-state. A stall (full, no grant) holds everything so the burst
  // resumes with the same owner and count once full clears.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    word_count_d = word_count_q;
    if (grant_vld) begin
      if (cont) begin
        burst_cnt_d = burst_cnt_q + BW'(1);
      end else begin
        // Also taken when the owner wins again: that starts a fresh burst.
        owner_d     = winner;
        burst_cnt_d = BW'(1);
        state_d     = BURST;
      end
      if (word_count_q != 16'hFFFF) begin
        word_count_d = word_count_q + 16'd1;
      end
    end else if (!full) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end
  end

  // Owner resets to the last index so requester 0 is first in line.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      state_q      <= IDLE;
      owner_q      <= OW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  assign owner      = owner_q;
  assign burst_cnt  = burst_cnt_q;
  assign busy       = (state_q == BURST);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int MB = 4;

  logic           w_clk = 1'b0;
  logic           wrst;
  logic [N-1:0]   req;
  logic [N*D-1:0] req_data;
  logic           full;
  logic [N-1:0]   gnt;
  logic           w_en;
  logic [D-1:0]   data_in;
  logic [1:0]     owner;
  logic [2:0]     burst_cnt;
  logic           busy;
  logic [15:0]    word_count;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers describing the arbitration rules.
  int m_owner = N - 1;
  int m_cnt   = 0;
  int m_busy  = 0;
  int m_words = 0;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_SIZE(D), .MAX_BURST(MB)) dut (
    .w_clk(w_clk), .wrst(wrst), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .w_en(w_en), .data_in(data_in), .owner(owner),
    .burst_cnt(burst_cnt), .busy(busy), .word_count(word_count)
  );

  always #5 w_clk = ~w_clk;

  function automatic bit exp_cont();
    return (m_busy != 0) && req[m_owner] && (m_cnt < MB);
  endfunction

  // Index granted this cycle, or -1 for no grant.
  function automatic int exp_win();
    if (wrst || full) return -1;
    if (exp_cont()) return m_owner;
    for (int k = 1; k <= N; k++)
      if (req[(m_owner + k) % N]) return (m_owner + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    int w;
    w = exp_win();
    return (w < 0) ? '0 : (N'(1) << w);
  endfunction

  function automatic logic [D-1:0] exp_data();
    int w;
    w = exp_win();
    return (w < 0) ? '0 : req_data[w*D +: D];
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  // Called with time at posedge+1; returns at the next posedge+1.
  task automatic step();
    int w;
    bit c;
    w = exp_win();
    c = exp_cont();
    #4;
    @(posedge w_clk);
    if (wrst) begin
      m_owner = N - 1; m_cnt = 0; m_busy = 0; m_words = 0;
    end else if (w >= 0) begin
      if (c) m_cnt++;
      else begin m_owner = w; m_cnt = 1; m_busy = 1; end
      if (m_words < 16'hFFFF) m_words++;
    end else if (!full) begin
      m_busy = 0; m_cnt = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1; req = '0; full = 1'b0;
    step(); step();
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1; req = 4'b1111; full = 1'b0; req_data = 32'hA1B2C3D4;
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++;
      if (gnt !== 4'b0000 || w_en !== 1'b0 || data_in !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d gnt=%b w_en=%b data_in=%h want 0/0/00", i, gnt, w_en, data_in);
      end
      step();
    end
    wrst = 1'b0; req = '0;
    checks++;
    if (owner !== 2'd3 || burst_cnt !== 3'd0 || busy !== 1'b0 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs owner=%0d burst=%0d busy=%b wc=%0d want 3/0/0/0", owner, burst_cnt, busy, word_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_data = $urandom;
      #4;
      checks++;
      if (gnt !== 4'b0001 || data_in !== req_data[7:0]) begin
        errors++;
        $display("FAIL single_gnt cyc %0d gnt=%b data=%h want 0001/%h", i, gnt, data_in, req_data[7:0]);
      end
      step();
      checks++;
      if (burst_cnt !== 3'((i % 4) + 1)) begin
        errors++;
        $display("FAIL single_burst cyc %0d got %0d want %0d", i, burst_cnt, (i % 4) + 1);
      end
    end
    checks++;
    if (word_count !== 16'd10) begin
      errors++;
      $display("FAIL single_wc got %0d want 10", word_count);
    end
  endtask

  task automatic test_all_rr();
    int e;
    do_reset();
    req = 4'b1111; full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req_data = $urandom;
      e = (i / 4) % 4;
      #4;
      checks++;
      if (gnt !== (N'(1) << e) || data_in !== req_data[e*D +: D]) begin
        errors++;
        $display("FAIL rr_seq cyc %0d gnt=%b data=%h want req %0d data %h", i, gnt, data_in, e, req_data[e*D +: D]);
      end
      step();
    end
  endtask

  task automatic test_full_stall();
    logic [N-1:0] seq [7];
    seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    do_reset();
    req = 4'b0011; req_data = 32'h44332211;
    for (int i = 0; i < 8; i++) begin
      full = (i >= 2 && i <= 4);
      #4;
      checks++;
      if (i < 7 ? (gnt !== seq[i] || w_en !== (seq[i] != 0)) : (gnt !== 4'b0001 && gnt !== 4'b0010)) begin
        errors++;
        $display("FAIL stall_gnt cyc %0d gnt=%b w_en=%b want %b", i, gnt, w_en, (i < 7) ? seq[i] : 4'b0010);
      end
      if (i == 7) begin
        checks++;
        if (gnt !== 4'b0010 || data_in !== 8'h22) begin
          errors++;
          $display("FAIL stall_switch gnt=%b data=%h want 0010/22", gnt, data_in);
        end
      end
      step();
      if (i >= 2 && i <= 4) begin
        checks++;
        if (burst_cnt !== 3'd2 || busy !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold cyc %0d burst=%0d busy=%b want 2/1", i, burst_cnt, busy);
        end
      end
    end
    full = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0101; full = 1'b0; req_data = 32'hDDCCBBAA;
    #4;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL drop_first gnt=%b want 0001", gnt);
    end
    step();
    req = 4'b0100;
    #4;
    checks++;
    if (gnt !== 4'b0100 || data_in !== 8'hCC) begin
      errors++;
      $display("FAIL drop_switch gnt=%b data=%h want 0100/cc", gnt, data_in);
    end
    step();
    checks++;
    if (owner !== 2'd2 || burst_cnt !== 3'd1) begin
      errors++;
      $display("FAIL drop_regs owner=%0d burst=%0d want 2/1", owner, burst_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1111; full = 1'b0; req_data = $urandom;
    repeat (11) step();
    checks++;
    if (owner !== 2'd2 || burst_cnt !== 3'd3) begin
      errors++;
      $display("FAIL midrst_pre owner=%0d burst=%0d want 2/3", owner, burst_cnt);
    end
    wrst = 1'b1;
    #4;
    checks++;
    if (gnt !== 4'b0000 || w_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_gnt gnt=%b w_en=%b want 0000/0", gnt, w_en);
    end
    step();
    wrst = 1'b0;
    #4;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_first gnt=%b want 0001", gnt);
    end
    step();
    checks++;
    if (burst_cnt !== 3'd1 || owner !== 2'd0) begin
      errors++;
      $display("FAIL midrst_post burst=%0d owner=%0d want 1/0", burst_cnt, owner);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req      = 4'($urandom);
      req_data = $urandom;
      full     = ($urandom_range(0, 4) == 0);
      wrst     = ($urandom_range(0, 60) == 0);
      #4;
      checks++;
      if (gnt !== exp_gnt() || w_en !== (exp_gnt() != 0) || data_in !== exp_data()) begin
        errors++;
        $display("FAIL rand_comb cyc %0d gnt=%b w_en=%b data=%h want %b/%h", i, gnt, w_en, data_in, exp_gnt(), exp_data());
      end
      checks++;
      if (full && w_en) begin
        errors++;
        $display("FAIL rand_full_write cyc %0d w_en=%b while full", i, w_en);
      end
      step();
      checks++;
      if (owner !== 2'(m_owner) || burst_cnt !== 3'(m_cnt) || busy !== (m_busy != 0) || word_count !== 16'(m_words)) begin
        errors++;
        $display("FAIL rand_regs cyc %0d owner=%0d burst=%0d busy=%b wc=%0d want %0d/%0d/%0d/%0d",
                 i, owner, burst_cnt, busy, word_count, m_owner, m_cnt, m_busy, m_words);
      end
    end
    wrst = 1'b0; full = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    req = 4'b0001; full = 1'b0; req_data = $urandom;
    repeat (65534) step();
    checks++;
    if (word_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_pre got %h want fffe", word_count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (word_count !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_hold write %0d got %h want ffff", i, word_count);
      end
    end
  endtask

  initial begin
    wrst = 1'b1; req = '0; full = 1'b0; req_data = '0;
    @(posedge w_clk);
    #1;
    test_reset();
    test_single();
    test_all_rr();
    test_full_stall();
    test_drop();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
